// File: rtl/gpo_led_pwm_dimmer_pkg.sv
// Shared definitions for the green-LED PWM dimmer: register map,
// CTRL bit layout and a small bus-decode helper.
package gpo_led_pwm_dimmer_pkg;

    // Register word addresses on the Avalon-MM slave
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PRESC  = 3'd1;
    localparam logic [2:0] ADDR_DUTY   = 3'd2;
    localparam logic [2:0] ADDR_BLINK  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_BLINK_EN_BIT = 1;
    localparam int CTRL_W            = 2;

    // Width of the blink half-period register (in frames)
    localparam int BLINK_BITS = 16;

    // Position of pwm_cnt inside STATUS
    localparam int STATUS_PWM_LSB = 8;

    // CTRL register image; field order matches the bit positions above
    typedef struct packed {
        logic blink_en;
        logic en;
    } ctrl_t;

    // Avalon write strobe: selected and write_n low
    function automatic logic is_write(input logic cs, input logic wr_n);
        return cs & ~wr_n;
    endfunction

endpackage

// File: rtl/gpo_led_pwm_dimmer_if.sv
// Avalon-MM slave bus of the LED dimmer (3-bit word address, 32-bit data,
// zero-wait-state combinational read).
interface gpo_led_pwm_dimmer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/gpo_led_pwm_dimmer_pwm_tick_gen.sv
// Prescaler plus PWM frame counter. While run is low both counters are
// held at zero so that enabling always begins a fresh frame.
module gpo_led_pwm_dimmer_pwm_tick_gen #(
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [PRESC_BITS-1:0] presc,
    output logic                  tick,
    output logic [PWM_BITS-1:0]   pwm_cnt,
    output logic                  frame_end
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic [PRESC_BITS-1:0] presc_cnt_reg;
    logic [PWM_BITS-1:0]   pwm_cnt_reg;

    // Tick when the prescaler has reached (or overshot) the divider; the >=
    // makes a divider shrunk below the running count fire on the next cycle.
    always_comb begin
        tick      = run && (presc_cnt_reg >= presc);
        frame_end = tick && (pwm_cnt_reg == PWM_MAX);
    end

    // Prescaler: free-running count, cleared on every tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt_reg <= '0;
        end else if (!run || tick) begin
            presc_cnt_reg <= '0;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + 1'b1;
        end
    end

    // PWM position within the frame, wrapping max -> 0 on the frame_end tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
        end else if (!run) begin
            pwm_cnt_reg <= '0;
        end else if (tick) begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    assign pwm_cnt = pwm_cnt_reg;

endmodule

// File: rtl/gpo_led_pwm_dimmer.sv
// Green-LED output stage: takes the GPO LED vector and drives the pins with
// global PWM brightness and optional blinking, or a plain registered copy
// of the GPO vector when disabled.
module gpo_led_pwm_dimmer
    import gpo_led_pwm_dimmer_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    gpo_led_pwm_dimmer_if.slave    bus,
    input  logic [N_LEDS-1:0]      gpo_in,
    output logic [N_LEDS-1:0]      led_out
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    // Register file
    ctrl_t                  ctrl_reg;
    logic [PRESC_BITS-1:0]  presc_reg;
    logic [PWM_BITS-1:0]    duty_reg;
    logic [BLINK_BITS-1:0]  blink_reg;

    // Frame shadows
    logic [N_LEDS-1:0]      gpo_q_reg;
    logic [PWM_BITS-1:0]    duty_q_reg;

    // Blink state
    logic [BLINK_BITS-1:0]  blink_cnt_reg;
    logic                   blink_phase_reg;
    logic                   blink_active;
    logic                   blink_phase;

    // Timing from the tick generator
    logic                   tick;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   frame_end;

    logic                   wr_en;
    logic                   pwm_on;
    logic                   lit;
    logic [N_LEDS-1:0]      led_next;
    logic [N_LEDS-1:0]      led_reg;
    logic [31:0]            readdata_next;

    // Only the low bits of writedata reach a register; fold the rest away
    logic                   unused_wdata;
    logic                   unused_tick;
    assign unused_wdata = ^bus.writedata;
    assign unused_tick  = tick;

    assign wr_en = is_write(bus.chipselect, bus.write_n);

    // Register writes; STATUS and addresses 5-7 have no writable state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg  <= '0;
            presc_reg <= '0;
            duty_reg  <= DUTY_MAX;
            blink_reg <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_CTRL:  ctrl_reg  <= ctrl_t'(bus.writedata[CTRL_W-1:0]);
                ADDR_PRESC: presc_reg <= bus.writedata[PRESC_BITS-1:0];
                ADDR_DUTY:  duty_reg  <= bus.writedata[PWM_BITS-1:0];
                ADDR_BLINK: blink_reg <= bus.writedata[BLINK_BITS-1:0];
                default: ;
            endcase
        end
    end

    gpo_led_pwm_dimmer_pwm_tick_gen #(
        .PWM_BITS   (PWM_BITS),
        .PRESC_BITS (PRESC_BITS)
    ) u_pwm_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (ctrl_reg.en),
        .presc     (presc_reg),
        .tick      (tick),
        .pwm_cnt   (pwm_cnt),
        .frame_end (frame_end)
    );

    // Shadows follow the live values while disabled and are only refreshed
    // at frame boundaries while enabled, so a frame never changes mid-way.
    // A write landing on the boundary edge is seen next frame, since the
    // register still holds its old value at that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpo_q_reg  <= '0;
            duty_q_reg <= DUTY_MAX;
        end else if (!ctrl_reg.en || frame_end) begin
            gpo_q_reg  <= gpo_in;
            duty_q_reg <= duty_reg;
        end
    end

    // Blinking runs only when enabled, blink-enabled and given a period
    assign blink_active = ctrl_reg.en & ctrl_reg.blink_en & (blink_reg != '0);

    // Count frames and toggle the phase every BLINK frames; >= rather than ==
    // so a period shortened below the running count still wraps promptly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
        end else if (!blink_active) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt_reg >= blink_reg - 1'b1) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg   <= blink_cnt_reg + 1'b1;
            end
        end
    end

    // Disabling blink forces the lit phase straight away, not one frame later
    assign blink_phase = blink_active ? blink_phase_reg : 1'b1;

    // Duty max is a solid on; otherwise on for the first duty_q ticks
    assign pwm_on = (duty_q_reg == DUTY_MAX) | (pwm_cnt < duty_q_reg);
    assign lit    = pwm_on & blink_phase;

    // Per-LED next value: gated shadow when enabled, raw GPO when disabled
    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_led
            assign led_next[gi] = ctrl_reg.en ? (gpo_q_reg[gi] & lit) : gpo_in[gi];
        end
    endgenerate

    // Single output register; no combinational path from gpo_in to the pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led_out = led_reg;

    // Zero-wait-state read mux, unused bits read as zero
    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_CTRL:   readdata_next[CTRL_W-1:0]     = ctrl_reg;
            ADDR_PRESC:  readdata_next[PRESC_BITS-1:0] = presc_reg;
            ADDR_DUTY:   readdata_next[PWM_BITS-1:0]   = duty_reg;
            ADDR_BLINK:  readdata_next[BLINK_BITS-1:0] = blink_reg;
            ADDR_STATUS: begin
                readdata_next[0] = blink_phase;
                readdata_next[STATUS_PWM_LSB +: PWM_BITS] = pwm_cnt;
            end
            default: ;
        endcase
    end

    assign bus.readdata = readdata_next;

endmodule
